kbd_scan_ctrl: RTL and testbench
================================

# kbd_scan_ctrl

- Sequences the raw PS/2 scan-code byte stream from the keyboard receiver into ASCII key events for the CPU.
- Decodes the set-2 prefix grammar (E0 extended, F0 break) with a state machine and tracks the Shift, Ctrl and Caps Lock modifiers.
- Queues translated make events in a small FIFO that the CPU drains with a read strobe, so the CPU no longer polls a single overwrite-prone latch.

## Interface
- FIFO_DEPTH, 8: key FIFO entries; power of two, minimum 2.
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- byte_vld  in  1  one-cycle pulse from the PS/2 receiver: a complete byte is on byte_in.
- byte_in  in  8  received scan-code byte; sampled only when byte_vld=1.
- rd_strb  in  1  CPU pop of the FIFO head; ignored when key_avail=0.
- ovf_clr  in  1  clears overflow.
- key_data  out  8  ASCII of the FIFO head; 0x00 when empty.
- key_avail  out  1  FIFO non-empty.
- key_count  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO.
- shift  out  1  left Shift (0x12) OR right Shift (0x59) held.
- ctrl  out  1  left Ctrl (0x14) OR right Ctrl (E0 14) held.
- caps  out  1  Caps Lock toggle state.
- overflow  out  1  sticky: a translated key was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK. Every transition happens only on byte_vld.
- Filtered bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE and 0xFF are ignored in every state. The state and all modifiers are unchanged.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - Any other byte is a make code; process it and stay in IDLE.
- IDLE make handling:
  - 0x12 sets lshift; 0x59 sets rshift; 0x14 sets lctrl.
  - 0x58 toggles caps only if caps_held=0, then sets caps_held. Typematic repeats therefore do not re-toggle.
  - Any other code goes through the scan2ascii lookup. A nonzero result is pushed; 0x00 means the key is unmapped and nothing is pushed.
- EXT transitions:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Any other byte is an extended make, then -> IDLE.
- EXT extended makes:
  - 0x14 sets rctrl.
  - 0x5A pushes 0x0D.
  - 0x4A pushes 0x2F.
  - All others are ignored, including E0 12 fake-shift.
- BRK: the byte is a break code, then -> IDLE. 0x12 clears lshift, 0x59 clears rshift, 0x14 clears lctrl, 0x58 clears caps_held. Any other byte (including E0) is ignored.
- EXT_BRK: 0x14 clears rctrl; all others are ignored; then -> IDLE.
- Translation rules:
  - Letters: output is uppercase iff shift XOR caps.
  - Digits and punctuation: shifted glyph iff shift; caps has no effect.
  - If ctrl is set and the key is a letter, push (uppercase ASCII & 0x1F).
  - Control keys: 0x5A=0x0D, 0x66=0x08, 0x0D=0x09, 0x76=0x1B, 0x29=0x20. These are unaffected by shift.
- FIFO rules:
  - Push and pop in the same cycle are both performed, including when full (the pop frees the slot).
  - Push when full without a pop: the byte is dropped, overflow is set, and the FIFO is unchanged.
  - rd_strb when empty: no effect; pointers never underflow.
  - ovf_clr in the same cycle as a new overflow: set wins.
- Reset (asynchronous): state=IDLE; shift=ctrl=caps=0; caps_held=0; FIFO empty; key_avail=0; key_count=0; key_data=0x00; overflow=0. Asserting rst mid-sequence (e.g. between E0 and the next byte) abandons the prefix.

## Timing
- byte_vld at cycle N: the state and modifier outputs update at the N+1 edge. A pushed key makes key_avail=1 and key_count+1 visible at N+1.
- key_data is a combinational read of the registered head. It is valid in the same cycle key_avail=1.
- rd_strb at cycle N: the next entry (or 0x00) appears at N+1, and key_count decrements at N+1.
- byte_vld on consecutive cycles is fully supported. There is no backpressure toward the receiver.
- Modifier updates from a byte take effect for the translation of the next byte, never the same byte.

## Structure
- Package kbd_pkg holds:
  - the state enum;
  - scan-code constants (E0, F0, SHIFT_L/R, CTRL, CAPS, filtered codes);
  - the function scan2ascii(code, shifted), covering the full US set-2 table (letters, digit row, punctuation), returning 0x00 for unmapped codes.
- Sub-module key_fifo holds the parameterized synchronous FIFO: push, pop, dout, count, full, empty.
- The FSM, modifier registers and overflow flag live in kbd_scan_ctrl.

## Test plan
- Reset, then bytes 1C, F0 1C -> one entry 0x61 ('a'); key_count=1; break pushes nothing.
- 12, 1C, 16, F0 12, 1C -> entries 0x41, 0x21, 0x61; shift=1 after the first byte and 0 after F0 12.
- 58, 58 (typematic), F0 58, 1C, 16 -> caps=1; entries 0x41, 0x31. A second 58 F0 58 -> caps=0.
- E0 14, 21, E0 F0 14, 21 -> ctrl pulses 1 then 0; entries 0x03, 0x63. E0 5A -> 0x0D. A filtered AA between E0 and 14 leaves the state as EXT.
- FIFO_DEPTH=8: push 9 keys with no reads -> key_count=8, overflow=1, head is still the first key. Push+pop in the same cycle while full -> count stays 8, no further overflow. ovf_clr -> overflow=0.
- Assert rst after E0 F0 -> all outputs at reset values; then 1C yields 0x61 (prefix discarded).

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types, scan-code constants and the US set-2 ASCII table
// used by the PS/2 key sequencer.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_SLASH   = 8'h4A;

  // Receiver status / keyboard housekeeping bytes, never key data
  function automatic logic is_filtered(input logic [7:0] code);
    return (code == 8'h00) || (code == 8'hAA) ||
           (code == 8'hEE) || (code == 8'hFA) ||
           (code == 8'hFC) || (code == 8'hFE) ||
           (code == 8'hFF);
  endfunction

  function automatic logic is_letter(input logic [7:0] code);
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
      8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
      8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
      8'h35, 8'h1A: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] scan2ascii(
    input logic [7:0] code,
    input logic       shifted
  );
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: {lo, hi} = {"a", "A"};
      8'h32: {lo, hi} = {"b", "B"};
      8'h21: {lo, hi} = {"c", "C"};
      8'h23: {lo, hi} = {"d", "D"};
      8'h24: {lo, hi} = {"e", "E"};
      8'h2B: {lo, hi} = {"f", "F"};
      8'h34: {lo, hi} = {"g", "G"};
      8'h33: {lo, hi} = {"h", "H"};
      8'h43: {lo, hi} = {"i", "I"};
      8'h3B: {lo, hi} = {"j", "J"};
      8'h42: {lo, hi} = {"k", "K"};
      8'h4B: {lo, hi} = {"l", "L"};
      8'h3A: {lo, hi} = {"m", "M"};
      8'h31: {lo, hi} = {"n", "N"};
      8'h44: {lo, hi} = {"o", "O"};
      8'h4D: {lo, hi} = {"p", "P"};
      8'h15: {lo, hi} = {"q", "Q"};
      8'h2D: {lo, hi} = {"r", "R"};
      8'h1B: {lo, hi} = {"s", "S"};
      8'h2C: {lo, hi} = {"t", "T"};
      8'h3C: {lo, hi} = {"u", "U"};
      8'h2A: {lo, hi} = {"v", "V"};
      8'h1D: {lo, hi} = {"w", "W"};
      8'h22: {lo, hi} = {"x", "X"};
      8'h35: {lo, hi} = {"y", "Y"};
      8'h1A: {lo, hi} = {"z", "Z"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, "~"};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h5D: {lo, hi} = {"\\", "|"};
      8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      8'h76: {lo, hi} = {8'h1B, 8'h1B};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      default: {lo, hi} = 16'h0000;
    endcase
    return shifted ? hi : lo;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Byte FIFO holding translated key events; a pop frees a slot
// for a push in the same cycle even when full.
module key_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [7:0]   din,
  output logic [7:0]   dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 set-2 prefix decoder with modifier tracking, feeding
// translated make events into a CPU-drained key FIFO.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          byte_vld,
  input  logic [7:0]                    byte_in,
  input  logic                          rd_strb,
  input  logic                          ovf_clr,
  output logic [7:0]                    key_data,
  output logic                          key_avail,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          shift,
  output logic                          ctrl,
  output logic                          caps,
  output logic                          overflow
);

  state_t     state, state_d;
  logic       lshift, lshift_d;
  logic       rshift, rshift_d;
  logic       lctrl, lctrl_d;
  logic       rctrl, rctrl_d;
  logic       caps_d;
  logic       caps_held, caps_held_d;
  logic       push;
  logic [7:0] push_data;
  logic       full;
  logic       empty;
  logic       letter;
  logic [7:0] xlat;

  assign shift     = lshift | rshift;
  assign ctrl      = lctrl | rctrl;
  assign key_avail = !empty;

  // Translation always uses the registered modifiers
  assign letter = is_letter(byte_in);
  assign xlat   = (letter && ctrl) ?
                  (scan2ascii(byte_in, 1'b1) & 8'h1F) :
                  scan2ascii(byte_in,
                             letter ? (shift ^ caps) : shift);

  always_comb begin
    state_d     = state;
    lshift_d    = lshift;
    rshift_d    = rshift;
    lctrl_d     = lctrl;
    rctrl_d     = rctrl;
    caps_d      = caps;
    caps_held_d = caps_held;
    push        = 1'b0;
    push_data   = 8'h00;
    if (byte_vld && !is_filtered(byte_in)) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            byte_in == SC_EXT:     state_d  = EXT;
            byte_in == SC_BRK:     state_d  = BRK;
            byte_in == SC_SHIFT_L: lshift_d = 1'b1;
            byte_in == SC_SHIFT_R: rshift_d = 1'b1;
            byte_in == SC_CTRL:    lctrl_d  = 1'b1;
            byte_in == SC_CAPS: begin
              if (!caps_held) caps_d = !caps;
              caps_held_d = 1'b1;
            end
            default: begin
              push_data = xlat;
              push      = (xlat != 8'h00);
            end
          endcase
        end
        EXT: begin
          unique case (1'b1)
            byte_in == SC_BRK: state_d = EXT_BRK;
            byte_in == SC_EXT: state_d = EXT;
            default: begin
              state_d = IDLE;
              if (byte_in == SC_CTRL) rctrl_d = 1'b1;
              if (byte_in == SC_ENTER) begin
                push      = 1'b1;
                push_data = 8'h0D;
              end
              if (byte_in == SC_SLASH) begin
                push      = 1'b1;
                push_data = 8'h2F;
              end
            end
          endcase
        end
        BRK: begin
          state_d = IDLE;
          if (byte_in == SC_SHIFT_L) lshift_d    = 1'b0;
          if (byte_in == SC_SHIFT_R) rshift_d    = 1'b0;
          if (byte_in == SC_CTRL)    lctrl_d     = 1'b0;
          if (byte_in == SC_CAPS)    caps_held_d = 1'b0;
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (byte_in == SC_CTRL) rctrl_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      lshift    <= lshift_d;
      rshift    <= rshift_d;
      lctrl     <= lctrl_d;
      rctrl     <= rctrl_d;
      caps      <= caps_d;
      caps_held <= caps_held_d;
      // A new drop beats a simultaneous clear
      if (push && full && !rd_strb)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_strb),
    .din   (push_data),
    .dout  (key_data),
    .count (key_count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl: byte sequences in, FIFO
// contents and modifier flags checked against hand-computed values.
module tb_kbd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_vld = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       rd_strb = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] key_data;
  logic       key_avail;
  logic [3:0] key_count;
  logic       shift;
  logic       ctrl;
  logic       caps;
  logic       overflow;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kbd_scan_ctrl #(
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_vld  (byte_vld),
    .byte_in   (byte_in),
    .rd_strb   (rd_strb),
    .ovf_clr   (ovf_clr),
    .key_data  (key_data),
    .key_avail (key_avail),
    .key_count (key_count),
    .shift     (shift),
    .ctrl      (ctrl),
    .caps      (caps),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in  = b;
    byte_vld = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_strb = 1'b1;
    @(negedge clk);
    rd_strb = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_avail"}, {7'd0, key_avail}, 8'h00);
    chk({tag, "_count"}, {4'd0, key_count}, 8'h00);
    chk({tag, "_data"},  key_data, 8'h00);
    chk({tag, "_mods"},  {5'd0, shift, ctrl, caps}, 8'h00);
    chk({tag, "_ovf"},   {7'd0, overflow}, 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");

    // make + break of 'a'
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("a_count", {4'd0, key_count}, 8'd1);
    chk("a_data", key_data, 8'h61);
    pop();
    chk("a_pop_count", {4'd0, key_count}, 8'd0);
    chk("a_pop_data", key_data, 8'h00);
    pop();
    chk("empty_pop_count", {4'd0, key_count}, 8'd0);

    // shift
    send(8'h12);
    chk("shift_on", {7'd0, shift}, 8'h01);
    send(8'h1C); send(8'h16);
    send(8'hF0); send(8'h12);
    chk("shift_off", {7'd0, shift}, 8'h00);
    send(8'h1C);
    chk("shift_count", {4'd0, key_count}, 8'd3);
    chk("shift_e0", key_data, 8'h41);
    pop();
    chk("shift_e1", key_data, 8'h21);
    pop();
    chk("shift_e2", key_data, 8'h61);
    pop();

    // caps lock with typematic repeat
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_on", {7'd0, caps}, 8'h01);
    send(8'h1C); send(8'h16);
    chk("caps_e0", key_data, 8'h41);
    pop();
    chk("caps_e1", key_data, 8'h31);
    pop();
    send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_off", {7'd0, caps}, 8'h00);

    // right ctrl, extended enter, filtered byte inside prefix
    send(8'hE0); send(8'h14);
    chk("rctrl_on", {7'd0, ctrl}, 8'h01);
    send(8'h21);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("rctrl_off", {7'd0, ctrl}, 8'h00);
    send(8'h21);
    chk("ctrl_e0", key_data, 8'h03);
    pop();
    chk("ctrl_e1", key_data, 8'h63);
    pop();
    send(8'hE0); send(8'h5A);
    chk("kp_enter", key_data, 8'h0D);
    pop();
    send(8'hE0); send(8'hAA); send(8'h14);
    chk("filt_ext", {7'd0, ctrl}, 8'h01);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("filt_ext_off", {7'd0, ctrl}, 8'h00);
    chk("filt_empty", {4'd0, key_count}, 8'd0);

    // overflow
    send(8'h15);
    for (int i = 0; i < 8; i++) send(8'h1C);
    chk("ovf_count", {4'd0, key_count}, 8'd8);
    chk("ovf_flag", {7'd0, overflow}, 8'h01);
    chk("ovf_head", key_data, 8'h71);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", {7'd0, overflow}, 8'h00);
    @(negedge clk);
    byte_in  = 8'h32;
    byte_vld = 1'b1;
    rd_strb  = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0;
    rd_strb  = 1'b0;
    chk("pp_count", {4'd0, key_count}, 8'd8);
    chk("pp_ovf", {7'd0, overflow}, 8'h00);
    chk("pp_head", key_data, 8'h61);
    for (int i = 0; i < 7; i++) pop();
    chk("pp_tail", key_data, 8'h62);
    pop();
    chk("drain_count", {4'd0, key_count}, 8'd0);

    // reset abandons a pending prefix
    send(8'hE0); send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    rst = 1'b0;
    send(8'h1C);
    chk("post_rst_count", {4'd0, key_count}, 8'd1);
    chk("post_rst_data", key_data, 8'h61);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
